// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed segment scanner.
// No logic; no latency.
// No flow control.
package seg_scan_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
    localparam int SEG_W  = SEG_DP + 1;

    localparam int DEF_SLOT_CYCLES  = 1024;
    localparam int DEF_BLANK_CYCLES = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter and round-robin digit index; flags the frame-end cycle and pulses frame_start.
// frame_start is registered, aligned with the output stage of the digit-0 cnt=0 cycle.
// No backpressure; dropping enable abandons the slot and returns to cnt=0, digit 0.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int IDX_W       = 2,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
    parameter int CNT_W       = $clog2(SLOT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             scan,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] cur_digit,
    output logic             frame_end,
    output logic             frame_start
);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] dig_q, dig_d;
    logic             last_cnt, last_dig;

    assign scan      = (state_q == SCAN) && enable;
    assign last_cnt  = (32'(cnt_q) == SLOT_CYCLES - 1);
    assign last_dig  = (32'(dig_q) == NUM_DIGITS - 1);
    assign frame_end = scan && last_cnt && last_dig;
    assign cnt       = cnt_q;
    assign cur_digit = dig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dig_q       <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            frame_start <= scan && (cnt_q == '0) && (dig_q == '0);
        end
    end

    // The first SCAN cycle always starts at cnt=0 of digit 0 because IDLE holds both at zero.
    always_comb begin
        state_d = enable ? SCAN : IDLE;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        if (!scan) begin
            cnt_d = '0;
            dig_d = '0;
        end else if (last_cnt) begin
            cnt_d = '0;
            dig_d = last_dig ? '0 : dig_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Multiplexes a double-buffered per-digit segment frame onto one segment bus with blanking and PWM.
// seg_out/dig_en are registered one cycle after the cnt/cur_digit state that selects them.
// wr_ready drops only in a frame-end cycle that swaps banks; the write then retries next cycle.
module seg_scan_scheduler
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int IDX_W        = 2,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [3:0]            bright,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [SEG_W-1:0]      wr_data,
    input  logic                  commit,
    output logic [SEG_W-1:0]      seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_start,
    output logic [IDX_W-1:0]      cur_digit,
    output logic                  wr_err
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);

    logic             scan, frame_end;
    logic [CNT_W-1:0] cnt;
    logic [SEG_W-1:0] shadow [NUM_DIGITS];
    logic [SEG_W-1:0] active [NUM_DIGITS];
    logic             pending_q, swap, wr_fire, in_range, lit;

    seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .IDX_W       (IDX_W),
        .SLOT_CYCLES (SLOT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .scan        (scan),
        .cnt         (cnt),
        .cur_digit   (cur_digit),
        .frame_end   (frame_end),
        .frame_start (frame_start)
    );

    // Outside SCAN there is no frame boundary, so a pending commit is published straight away.
    assign swap     = (frame_end && (pending_q || commit)) || (!scan && pending_q);
    assign wr_ready = !(frame_end && (pending_q || commit));
    assign wr_fire  = wr_valid && wr_ready;
    assign in_range = 32'(wr_idx) < NUM_DIGITS;
    assign lit      = scan && (32'(cnt) >= BLANK_CYCLES) && (cnt[3:0] < bright);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            wr_err    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            pending_q <= swap ? 1'b0 : (pending_q || commit);
            wr_err    <= wr_err || (wr_fire && !in_range);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_fire && in_range && (wr_idx == IDX_W'(i)))
                    shadow[i] <= wr_data;
                if (swap)
                    active[i] <= shadow[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out <= '0;
            dig_en  <= '0;
        end else begin
            seg_out <= lit ? active[cur_digit] : '0;
            dig_en  <= lit ? (NUM_DIGITS'(1) << cur_digit) : '0;
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: position-based scoreboard plus brightness table and corner sequences.
module tb_seg_scan_scheduler;

    localparam int N = 4, SLOT = 64, BLANK = 16, FRAME = N * SLOT;
    localparam int N2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, wr_valid, commit, wr_ready, frame_start, wr_err;
    logic [3:0] bright, dig_en;
    logic [1:0] wr_idx, cur_digit;
    logic [7:0] wr_data, seg_out;

    logic       b_enable, b_wr_valid, b_wr_ready, b_commit, b_frame_start, b_wr_err;
    logic [3:0] b_bright;
    logic [1:0] b_wr_idx, b_cur_digit;
    logic [7:0] b_wr_data, b_seg_out;
    logic [2:0] b_dig_en;

    seg_scan_scheduler #(.NUM_DIGITS(N), .IDX_W(2), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bright(bright),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
        .commit(commit), .seg_out(seg_out), .dig_en(dig_en), .frame_start(frame_start),
        .cur_digit(cur_digit), .wr_err(wr_err)
    );

    seg_scan_scheduler #(.NUM_DIGITS(N2), .IDX_W(2), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut3 (
        .clk(clk), .rst(rst), .enable(b_enable), .bright(b_bright),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_idx(b_wr_idx), .wr_data(b_wr_data),
        .commit(b_commit), .seg_out(b_seg_out), .dig_en(b_dig_en), .frame_start(b_frame_start),
        .cur_digit(b_cur_digit), .wr_err(b_wr_err)
    );

    typedef struct {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       fs;
        logic [1:0] cd;
    } exp_t;

    typedef struct {
        logic [3:0] br;
        int         exp_lit;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[5];
    logic [7:0] pat[N];
    logic [7:0] m_sh[N];
    logic [7:0] m_act[N];
    int         m_p;
    bit         m_inscan, m_pend;
    int         checks = 0, failures = 0;
    int         lit_cnt, fs_cnt, rdy_low_cnt, b_lit_cnt, b_seg_cnt;
    bit         last_acc;
    logic       last_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge with this cycle's inputs driven; returns at the next falling edge.
    task automatic step();
        exp_t e;
        int   cnt, dig, nxt_p;
        bit   scan, fe, rdy, swap;
        #1;
        scan  = m_inscan && enable;
        cnt   = m_p % SLOT;
        dig   = (m_p / SLOT) % N;
        fe    = scan && ((m_p % FRAME) == FRAME - 1);
        rdy   = !(fe && (m_pend || commit));
        last_rdy = wr_ready;
        chk("wr_ready", {31'b0, wr_ready}, {31'b0, rdy});
        if (!wr_ready) rdy_low_cnt++;
        nxt_p = scan ? m_p + 1 : 0;
        e.seg = '0;
        e.dig = '0;
        e.fs  = scan && ((m_p % FRAME) == 0);
        e.cd  = 2'((nxt_p / SLOT) % N);
        if (scan && cnt >= BLANK && (cnt % 16) < int'(bright)) begin
            e.seg = m_act[dig];
            e.dig = 4'(1 << dig);
        end
        sb.push_back(e);
        swap     = (fe && (m_pend || commit)) || (!scan && m_pend);
        last_acc = wr_valid && rdy;
        if (swap) begin
            m_act  = m_sh;
            m_pend = 0;
        end else if (commit) begin
            m_pend = 1;
        end
        if (last_acc) m_sh[wr_idx] = wr_data;
        m_p      = nxt_p;
        m_inscan = enable;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("out{seg,dig,fs,cd}", {17'b0, seg_out, dig_en, frame_start, cur_digit},
                {17'b0, e.seg, e.dig, e.fs, e.cd});
        end
        if (dig_en != 0) lit_cnt++;
        if (frame_start) fs_cnt++;
        if (b_dig_en != 0) b_lit_cnt++;
        if (b_seg_out != 0) b_seg_cnt++;
    endtask

    // Advance until the outputs on the bus reflect frame position p.
    task automatic goto(input int p);
        int guard = 0;
        while ((m_p % FRAME) != p && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        if (guard >= 2 * FRAME) begin
            checks++;
            failures++;
            $display("FAIL goto_timeout actual_pos=%0d required_pos=%0d", m_p % FRAME, p);
        end
        step();
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [7:0] data);
        int tries = 0;
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_data  = data;
        do begin
            step();
            tries++;
        end while (!last_acc && tries < 4);
        wr_valid = 1'b0;
        chk("write_accepted", {31'b0, last_acc}, 32'd1);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd15, 4 * 45};
        vecs[1] = '{4'd4,  4 * 12};
        vecs[2] = '{4'd0,  0};
        vecs[3] = '{4'd8,  4 * 24};
        vecs[4] = '{4'd1,  4 * 3};
        pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B; pat[3] = 8'h4F;
        for (int i = 0; i < N; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_p = 0; m_inscan = 0; m_pend = 0;
        lit_cnt = 0; fs_cnt = 0; rdy_low_cnt = 0; b_lit_cnt = 0; b_seg_cnt = 0;

        enable = 0; bright = 4'd15; wr_valid = 0; wr_idx = 0; wr_data = 0; commit = 0;
        b_enable = 0; b_bright = 4'd15; b_wr_valid = 0; b_wr_idx = 0; b_wr_data = 0; b_commit = 0;
        rst = 0;
        #1 rst = 1;
        #1;
        chk("rst_seg", {24'b0, seg_out}, 32'd0);
        chk("rst_dig", {28'b0, dig_en}, 32'd0);
        chk("rst_fs", {31'b0, frame_start}, 32'd0);
        chk("rst_cd", {30'b0, cur_digit}, 32'd0);
        chk("rst_err", {31'b0, wr_err}, 32'd0);
        chk("rst_ready", {31'b0, wr_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // Load a frame and publish it.
        enable = 1;
        for (int k = 0; k < N; k++) do_write(2'(k), pat[k]);
        do_commit();
        goto(FRAME - 1);
        for (int k = 0; k < N; k++) begin
            goto(k * SLOT + BLANK - 1);
            chk("blank_dig", {28'b0, dig_en}, 32'd0);
            step();
            chk("digit_seg", {24'b0, seg_out}, {24'b0, pat[k]});
            chk("digit_en", {28'b0, dig_en}, 32'(1 << k));
        end

        // Brightness table: lit cycles and frame_start pulses over one full frame.
        for (int i = 0; i < 5; i++) begin
            bright = vecs[i].br;
            goto(FRAME - 1);
            lit_cnt = 0;
            fs_cnt  = 0;
            repeat (FRAME) step();
            chk("lit_per_frame", lit_cnt, vecs[i].exp_lit);
            chk("fs_per_frame", fs_cnt, 32'd1);
        end
        bright = 4'd15;

        // Shadow write without commit stays invisible; a mid-frame commit lands at the next frame.
        do_write(2'd2, 8'h7F);
        repeat (3) begin
            goto(2 * SLOT + BLANK);
            chk("uncommitted", {24'b0, seg_out}, 32'h5B);
        end
        goto(100);
        rdy_low_cnt = 0;
        do_commit();
        goto(2 * SLOT + BLANK);
        chk("same_frame_old", {24'b0, seg_out}, 32'h5B);
        goto(2 * SLOT + BLANK);
        chk("next_frame_new", {24'b0, seg_out}, 32'h7F);
        chk("ready_low_cycles", rdy_low_cnt, 32'd1);

        // Commit and write collide on the frame-end cycle.
        goto(FRAME - 2);
        commit = 1; wr_valid = 1; wr_idx = 2'd1; wr_data = 8'h77;
        step();
        commit = 0;
        chk("fe_stall", {31'b0, last_rdy}, 32'd0);
        step();
        chk("write_after_stall", {31'b0, last_rdy}, 32'd1);
        wr_valid = 0;
        goto(SLOT + BLANK);
        chk("swap_old_shadow", {24'b0, seg_out}, 32'h06);
        goto(SLOT + BLANK);
        chk("needs_recommit", {24'b0, seg_out}, 32'h06);
        do_commit();
        goto(SLOT + BLANK);
        chk("recommit_visible", {24'b0, seg_out}, 32'h77);

        // Out-of-range write on the three-digit instance.
        b_wr_valid = 1; b_wr_idx = 2'd3; b_wr_data = 8'hFF;
        step();
        b_wr_valid = 0;
        chk("wr_err_set", {31'b0, b_wr_err}, 32'd1);
        repeat (5) step();
        chk("wr_err_sticky", {31'b0, b_wr_err}, 32'd1);
        b_commit = 1;
        step();
        b_commit = 0;
        repeat (2) step();
        b_enable = 1;
        repeat (4) step();
        b_lit_cnt = 0;
        b_seg_cnt = 0;
        repeat (N2 * SLOT) step();
        chk("n3_lit", b_lit_cnt, 32'd135);
        chk("n3_banks_clean", b_seg_cnt, 32'd0);
        chk("main_no_err", {31'b0, wr_err}, 32'd0);

        // Abandon a slot mid-ON phase, then restart.
        goto(2 * SLOT + 30);
        chk("pre_drop_lit", {28'b0, dig_en}, 32'b0100);
        enable = 0;
        step();
        chk("drop_dark", {20'b0, seg_out, dig_en}, 32'd0);
        repeat (9) step();
        chk("idle_cd", {30'b0, cur_digit}, 32'd0);
        enable = 1;
        step();
        chk("restart_no_fs_yet", {31'b0, frame_start}, 32'd0);
        step();
        chk("restart_fs", {31'b0, frame_start}, 32'd1);
        chk("restart_blank", {28'b0, dig_en}, 32'd0);

        // Asynchronous reset in the middle of an ON phase.
        goto(20);
        chk("pre_rst_lit", {28'b0, dig_en}, 32'b0001);
        #2 rst = 1;
        #1;
        chk("arst_seg", {24'b0, seg_out}, 32'd0);
        chk("arst_dig", {28'b0, dig_en}, 32'd0);
        chk("arst_fs", {31'b0, frame_start}, 32'd0);
        chk("arst_cd", {30'b0, cur_digit}, 32'd0);
        chk("arst_err3", {31'b0, b_wr_err}, 32'd0);
        @(negedge clk);
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
Time-shares one 8-bit segment bus (7 segments + dp) across NUM_DIGITS common-cathode digits, so several snake/pattern engines can drive a multi-digit display.
- Holds a double-buffered frame of per-digit segment patterns.
- Scans the digits round-robin, with a blanking gap at the start of each digit slot to prevent ghosting.
- Applies 4-bit PWM brightness.
- Sits between the pattern generators (write port) and the top-level uo_out/uio_out pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
IDX_W, 2, width of digit index; must equal clog2(NUM_DIGITS), minimum 1
SLOT_CYCLES, 1024, clocks per digit slot; multiple of 16, > BLANK_CYCLES
BLANK_CYCLES, 64, blanked clocks at slot start; multiple of 16

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  scan enable; low = display dark, scan held
bright  in  4  PWM duty, lit 1/16 × bright during ON phase (0 = dark)
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_idx  in  IDX_W  target digit of write
wr_data  in  8  segment pattern {dp,g,f,e,d,c,b,a}, bit0 = segment a
commit  in  1  single-cycle pulse: publish shadow bank at next frame boundary
seg_out  out  8  segment drive, active high
dig_en  out  NUM_DIGITS  digit select, one-hot or zero
frame_start  out  1  one-cycle pulse at first cycle of a frame (digit 0 slot)
cur_digit  out  IDX_W  digit index of current slot
wr_err  out  1  sticky: write with wr_idx >= NUM_DIGITS occurred

Behaviour:
- Reset (async, rst=1):
  - seg_out=0, dig_en=0, frame_start=0, cur_digit=0, wr_err=0, wr_ready=1.
  - Shadow and active banks all 0; commit-pending flag 0; slot counter cnt=0.
- State machine:
  - IDLE: enable=0. Outputs dark; cnt and cur_digit held at 0; writes/commits still accepted.
  - SCAN: enable=1.
  - IDLE->SCAN: on enable=1; first SCAN cycle is cnt=0, digit 0, and frame_start pulses.
  - SCAN->IDLE: on enable=0 in any cycle; outputs go dark next cycle, cnt and cur_digit reset to 0.
- Slot timing (SCAN):
  - cnt counts 0..SLOT_CYCLES-1 and wraps.
  - On wrap, cur_digit increments mod NUM_DIGITS.
  - Frame end = cnt==SLOT_CYCLES-1 and cur_digit==NUM_DIGITS-1.
- Drive timing:
  - cnt < BLANK_CYCLES: blank phase; dig_en=0, seg_out=0.
  - Otherwise ON phase, lit when cnt[3:0] < bright. When lit: dig_en = one-hot(cur_digit), seg_out = active[cur_digit]; when not lit: both 0.
  - seg_out/dig_en are registered: one-cycle latency from the cnt/cur_digit state that selects them.
  - frame_start is aligned with the registered outputs of the slot's cnt=0 cycle.
- Write port:
  - An accepted write stores wr_data into shadow[wr_idx] at the clock edge.
  - wr_idx >= NUM_DIGITS: accepted, data dropped, wr_err set; cleared only by rst.
  - Writes never touch the active bank directly.
- Commit/swap:
  - commit sets pending.
  - At the frame-end cycle, if (pending | commit): active <= shadow, pending cleared.
  - The next frame's digit 0 displays new data.
  - wr_ready=0 only in a frame-end cycle where a swap occurs, so a write cannot race the copy.
  - A commit arriving while pending is already set is absorbed (no double swap).
  - In IDLE, a pending commit swaps immediately on the next cycle (there are no frame boundaries).
- enable deasserted mid-slot: the slot is abandoned, not finished.
- bright changes take effect on the next cycle's compare; no glitch protection required.

Decomposition:
- Package seg_scan_pkg:
  - segment bit positions SEG_A..SEG_G, SEG_DP;
  - state enum {IDLE, SCAN};
  - default SLOT_CYCLES/BLANK_CYCLES constants.
- Sub-module seg_scan_timer: owns cnt, cur_digit, frame-end and frame_start generation; has enable input.
- The parent holds the banks, the commit logic and the output registers.

Test Plan (NUM_DIGITS=4, SLOT_CYCLES=64, BLANK_CYCLES=16, bright=15 unless stated):
1. Reset, enable=1, write 0x3F/0x06/0x5B/0x4F to idx 0..3, commit -> after the next frame boundary, each digit's ON phase shows its pattern with dig_en 0001/0010/0100/1000; first 16 cycles of each slot are dark; frame_start every 256 cycles.
2. bright=4 -> in each ON phase, lit exactly on cycles where cnt[3:0] is 0..3: 12 lit of 48. bright=0 -> dig_en stays 0.
3. Write 0x7F to idx 2 without commit -> display unchanged over 3 frames; then commit mid-frame -> digit 2 changes only in the following frame; wr_ready low exactly 1 cycle at frame end.
4. Commit and wr_valid in the same frame-end cycle -> write stalled one cycle, swap uses the old shadow, the write lands afterward and needs another commit.
5. Write with wr_idx=3 at NUM_DIGITS=3 -> wr_err=1 and stays 1; no bank changes.
6. Drop enable at digit 2, cnt=30, for 10 cycles, then re-raise -> outputs dark next cycle; on restart, frame_start pulses and digit 0 begins with the blank phase. Assert rst mid-ON phase -> all outputs 0 immediately, asynchronously.
